fx3_bus_in_capture: RTL and testbench
=====================================

Name: fx3_bus_in_capture

Overview:
- Downstream stage of the FX3 inbound read path.
- Arms the read path only when the local buffer has room for a whole packet.
- Captures each FX3 bus word qualified by the path's data-valid strobe into an internal first-word-fall-through FIFO.
- Presents captured words to the core as a valid/ready stream with an end-of-packet marker, and flags short packets, long packets and overflow.

Parameters:
DATA_WIDTH, 32, width of FX3 data bus and output stream
ADDR_WIDTH, 9, FIFO address bits; DEPTH = 2**ADDR_WIDTH words (512)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_read_request  input  1  single-cycle pulse from master: capture one packet
i_packet_size  input  24  words in packet; sampled on accepted i_read_request
o_request_ack  output  1  single-cycle pulse: request accepted
i_fx3_data  input  DATA_WIDTH  registered FX3 data bus
i_data_valid  input  1  word strobe from inbound read path
i_in_path_busy  input  1  read path active
i_in_path_finished  input  1  read path finished, holds until enable drops
o_in_path_enable  output  1  enable to inbound read path
o_data  output  DATA_WIDTH  stream data
o_valid  output  1  stream valid
i_ready  input  1  stream ready
o_last  output  1  qualifies o_data as final word of packet
o_fifo_count  output  ADDR_WIDTH+1  words held, 0..DEPTH
o_busy  output  1  state != IDLE
o_short_packet  output  1  sticky; cleared on next accepted request
o_long_packet  output  1  sticky; cleared on next accepted request
o_overflow  output  1  sticky; cleared on next accepted request
o_size_error  output  1  sticky; cleared on next accepted request

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- FIFO storage: DATA_WIDTH+1 bits per entry (data plus last flag). o_fifo_count equals writes minus pops.
- Write and pop may occur in the same cycle. In that case the count is unchanged.
- FWFT output: a word written at edge N drives o_valid=1 from cycle N+1.
- Pop occurs when o_valid && i_ready.

State machine:
- IDLE
  - i_read_request with size 0: ignored. No ack, no flag changes.
  - i_read_request with size > DEPTH: sets o_size_error, stays IDLE, no ack.
  - Any other i_read_request: latch size into r_size, clear the four sticky flags, zero r_wcount, pulse o_request_ack, go to ARM.
  - i_read_request outside IDLE: ignored.
- ARM: wait until (DEPTH − o_fifo_count) >= r_size, then go to CAPTURE. Pops continue during this wait.
- CAPTURE
  - o_in_path_enable=1.
  - Each i_data_valid:
    - If r_wcount < r_size and FIFO not full: write the word, setting last = (r_wcount == r_size−1).
    - Else if r_wcount >= r_size: drop the word and set o_long_packet.
    - Else (FIFO full): drop the word and set o_overflow.
    - In all three cases, r_wcount saturates at r_size.
  - On i_in_path_finished, go to RELEASE. If i_data_valid is high in that same cycle, that word is still processed.
- RELEASE
  - o_in_path_enable=0.
  - If r_wcount < r_size, set o_short_packet on entry. The last flag is then never written for this packet.
  - Return to IDLE when i_in_path_finished is low.
- i_data_valid outside CAPTURE: ignored.
- Asynchronous reset mid-operation: FIFO flushed, enable dropped immediately, state returns to IDLE.

Widths and counters:
- r_wcount is 24 bits.
- Pointers are ADDR_WIDTH bits and wrap at DEPTH.
- Full is count==DEPTH; empty is count==0.

Test Plan:
- Request size 4, path returns 4 valid words 0xA0..0xA3, i_ready=1 -> o_request_ack one cycle; enable high in CAPTURE; stream outputs A0..A3, o_last only with A3; no flags set; back to IDLE after finished drops.
- Request size 8, i_ready=0, path returns 8 words; then a second request of size 508 -> first packet captured and o_fifo_count=8; second request stays in ARM until 4 words popped, then enable asserts.
- Request size 3, path delivers 5 valid words -> 3 words stored with last on the third; o_long_packet=1; o_fifo_count=3.
- Request size 6, path delivers 4 words then finished -> 4 words stored, none with o_last; o_short_packet=1; next accepted request clears the flag.
- Request size 0 -> no ack, stays IDLE. Request size 513 -> o_size_error=1, no ack. Then request size 2 -> error cleared, ack pulses.
- Assert rst during CAPTURE after 2 of 4 words -> o_in_path_enable falls without waiting for clk; o_fifo_count=0; o_valid=0; state IDLE.

Source files
------------

// File: rtl/fx3_bus_in_capture.sv
// fx3_bus_in_capture: arms the FX3 inbound read path when a whole packet fits,
// captures strobed bus words into a FWFT FIFO and streams them out with end-of-packet marking.
module fx3_bus_in_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read_request,
    input  logic [23:0]           i_packet_size,
    output logic                  o_request_ack,
    input  logic [DATA_WIDTH-1:0] i_fx3_data,
    input  logic                  i_data_valid,
    input  logic                  i_in_path_busy,
    input  logic                  i_in_path_finished,
    output logic                  o_in_path_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic [ADDR_WIDTH:0]   o_fifo_count,
    output logic                  o_busy,
    output logic                  o_short_packet,
    output logic                  o_long_packet,
    output logic                  o_overflow,
    output logic                  o_size_error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [23:0]           size_q, size_d, wcount_q, wcount_d;
    logic                  ack_q, ack_d;
    logic                  short_q, short_d, long_q, long_d, ovf_q, ovf_d, serr_q, serr_d;
    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   rd_word;
    logic                  wr_en, wr_last, pop, full, in_room;
    logic [23:0]           room;

    assign full     = count_q == (ADDR_WIDTH+1)'(DEPTH);
    assign room     = 24'(DEPTH) - 24'(count_q);
    assign in_room  = wcount_q < size_q;
    assign wr_last  = wcount_q == size_q - 24'd1;
    assign pop      = o_valid && i_ready;
    assign rd_word  = mem[rptr_q];

    assign o_valid          = count_q != '0;
    assign o_data           = rd_word[DATA_WIDTH-1:0];
    assign o_last           = o_valid && rd_word[DATA_WIDTH];
    assign o_fifo_count     = count_q;
    assign o_busy           = state_q != IDLE;
    assign o_in_path_enable = state_q == CAPTURE;
    assign o_request_ack    = ack_q;
    assign o_short_packet   = short_q;
    assign o_long_packet    = long_q;
    assign o_overflow       = ovf_q;
    assign o_size_error     = serr_q;

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        wcount_d = wcount_q;
        ack_d    = 1'b0;
        short_d  = short_q;
        long_d   = long_q;
        ovf_d    = ovf_q;
        serr_d   = serr_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read_request && i_packet_size != '0) begin
                    if (i_packet_size > 24'(DEPTH)) begin
                        serr_d = 1'b1;
                    end else begin
                        size_d   = i_packet_size;
                        wcount_d = '0;
                        ack_d    = 1'b1;
                        {short_d, long_d, ovf_d, serr_d} = '0;
                        state_d  = ARM;
                    end
                end
            end
            ARM: state_d = room >= size_q ? CAPTURE : ARM;
            CAPTURE: begin
                if (i_data_valid) begin
                    wr_en    = in_room && !full;
                    long_d   = long_q | !in_room;
                    ovf_d    = ovf_q | (in_room && full);
                    wcount_d = in_room ? wcount_q + 24'd1 : wcount_q;
                end
                // a word strobed alongside finished still counts toward the short-packet decision
                if (i_in_path_finished) begin
                    state_d = RELEASE;
                    short_d = short_q | (wcount_d < size_q);
                end
            end
            RELEASE: state_d = i_in_path_finished ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            size_q   <= '0;
            wcount_q <= '0;
            ack_q    <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            ovf_q    <= 1'b0;
            serr_q   <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            wcount_q <= wcount_d;
            ack_q    <= ack_d;
            short_q  <= short_d;
            long_q   <= long_d;
            ovf_q    <= ovf_d;
            serr_q   <= serr_d;
            wptr_q   <= wr_en ? wptr_q + 1'b1 : wptr_q;
            rptr_q   <= pop ? rptr_q + 1'b1 : rptr_q;
            count_q  <= count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= {wr_last, i_fx3_data};
    end

    logic unused_ok;
    assign unused_ok = i_in_path_busy;
endmodule

// File: tb/tb_fx3_bus_in_capture.sv
// tb_fx3_bus_in_capture: table-driven and randomized packet checks for fx3_bus_in_capture
// against a queue-based scoreboard of the words and end markers that should emerge.
module tb_fx3_bus_in_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read_request = 1'b0;
    logic [23:0] i_packet_size = '0;
    logic        o_request_ack;
    logic [31:0] i_fx3_data = '0;
    logic        i_data_valid = 1'b0;
    logic        i_in_path_busy = 1'b0;
    logic        i_in_path_finished = 1'b0;
    logic        o_in_path_enable;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        o_last;
    logic [9:0]  o_fifo_count;
    logic        o_busy, o_short_packet, o_long_packet, o_overflow, o_size_error;

    fx3_bus_in_capture dut (
        .clk(clk), .rst(rst),
        .i_read_request(i_read_request), .i_packet_size(i_packet_size), .o_request_ack(o_request_ack),
        .i_fx3_data(i_fx3_data), .i_data_valid(i_data_valid), .i_in_path_busy(i_in_path_busy),
        .i_in_path_finished(i_in_path_finished), .o_in_path_enable(o_in_path_enable),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_fifo_count(o_fifo_count), .o_busy(o_busy), .o_short_packet(o_short_packet),
        .o_long_packet(o_long_packet), .o_overflow(o_overflow), .o_size_error(o_size_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int ready_mode = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        int          size;
        int          nwords;
        logic [31:0] base;
        int          exp_count;
        logic        exp_long;
        logic        exp_short;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // every accepted word leaves the stream in order with its end marker
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {31'd0, o_last, o_data}, 64'h1_FFFF_FFFF);
            end else begin
                check("stream_data", o_data, exp_q[0][31:0]);
                check("stream_last", o_last, exp_q[0][32]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_ready = ready_mode == 2 ? 1'($urandom % 2) : ready_mode[0];
    endtask

    task automatic request(input int size, output logic acked);
        i_read_request = 1'b1;
        i_packet_size  = 24'(size);
        step();
        i_read_request = 1'b0;
        acked = o_request_ack;
        step();
        check("ack_single_cycle", o_request_ack, 1'b0);
    endtask

    task automatic wait_enable();
        int t = 0;
        while (!o_in_path_enable && t < 1000) begin
            step();
            t++;
        end
        check("enable_in_capture", o_in_path_enable, 1'b1);
    endtask

    task automatic deliver(input int size, input int n, input logic [31:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom % 3 == 0)) step();
            i_fx3_data   = base + 32'(i);
            i_data_valid = 1'b1;
            if (i < size) exp_q.push_back({i == size - 1, base + 32'(i)});
            step();
            i_data_valid = 1'b0;
        end
    endtask

    task automatic finish_path();
        i_in_path_finished = 1'b1;
        step();
        check("enable_dropped", o_in_path_enable, 1'b0);
        step();
        check("busy_in_release", o_busy, 1'b1);
        i_in_path_finished = 1'b0;
        step();
        check("idle_after_release", o_busy, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        ready_mode = 1;
        i_ready = 1'b1;
        while ((o_fifo_count != 0 || exp_q.size() != 0) && t < 2000) begin
            step();
            t++;
        end
        check("drained_count", o_fifo_count, 10'd0);
        check("drained_scoreboard", exp_q.size(), 0);
        ready_mode = 0;
        i_ready = 1'b0;
    endtask

    task automatic run_packet(input int size, input int n, input logic [31:0] base, input bit gaps);
        logic acked;
        request(size, acked);
        check("ack", acked, 1'b1);
        wait_enable();
        deliver(size, n, base, gaps);
        finish_path();
    endtask

    initial begin
        vec_t vecs[5];
        logic acked;
        vecs[0] = '{4, 4, 32'hA0, 4, 1'b0, 1'b0};
        vecs[1] = '{3, 5, 32'hB0, 3, 1'b1, 1'b0};
        vecs[2] = '{6, 4, 32'hC0, 4, 1'b0, 1'b1};
        vecs[3] = '{1, 1, 32'hD0, 1, 1'b0, 1'b0};
        vecs[4] = '{16, 0, 32'hE0, 0, 1'b0, 1'b1};

        step(); step();
        check("reset_outputs",
              {o_request_ack, o_in_path_enable, o_valid, o_last, o_busy, o_short_packet,
               o_long_packet, o_overflow, o_size_error, o_fifo_count}, 19'd0);
        rst = 1'b0;
        step();

        // streaming while capturing: A0..A3 with last only on A3
        ready_mode = 1;
        i_ready = 1'b1;
        run_packet(4, 4, 32'hA0, 1'b0);
        drain();
        check("flags_clean", {o_short_packet, o_long_packet, o_overflow, o_size_error}, 4'd0);

        foreach (vecs[k]) begin
            run_packet(vecs[k].size, vecs[k].nwords, vecs[k].base, 1'b0);
            check("vec_count", o_fifo_count, 10'(vecs[k].exp_count));
            check("vec_long", o_long_packet, vecs[k].exp_long);
            check("vec_short", o_short_packet, vecs[k].exp_short);
            check("vec_overflow", o_overflow, 1'b0);
            drain();
        end

        // room wait: 8 held, 508 needs four pops before arming the path
        run_packet(8, 8, 32'h100, 1'b0);
        check("held_8", o_fifo_count, 10'd8);
        request(508, acked);
        check("ack_508", acked, 1'b1);
        repeat (5) step();
        check("arm_waits", o_in_path_enable, 1'b0);
        check("arm_busy", o_busy, 1'b1);
        ready_mode = 1;
        i_ready = 1'b1;
        step(); step(); step();
        ready_mode = 0;
        step();
        check("after_4_pops", o_fifo_count, 10'd4);
        wait_enable();
        finish_path();
        check("short_508", o_short_packet, 1'b1);
        drain();

        // zero-size ignored, oversize flagged, valid request clears the error
        request(0, acked);
        check("size0_no_ack", acked, 1'b0);
        check("size0_idle", o_busy, 1'b0);
        check("size0_flag_kept", o_short_packet, 1'b1);
        request(513, acked);
        check("size513_no_ack", acked, 1'b0);
        check("size513_error", o_size_error, 1'b1);
        check("size513_idle", o_busy, 1'b0);
        request(512, acked);
        check("size512_ack", acked, 1'b1);
        check("size512_error_clear", o_size_error, 1'b0);
        wait_enable();
        finish_path();
        request(2, acked);
        check("size2_ack", acked, 1'b1);
        check("size2_short_clear", o_short_packet, 1'b0);
        wait_enable();
        deliver(2, 2, 32'h200, 1'b0);
        finish_path();
        drain();

        // randomized packets with random gaps and random downstream ready
        for (int r = 0; r < 25; r++) begin
            int sz = 1 + int'($urandom % 12);
            int nw = int'($urandom % 16);
            ready_mode = 2;
            run_packet(sz, nw, $urandom, 1'b1);
            check("rnd_long", o_long_packet, nw > sz);
            check("rnd_short", o_short_packet, nw < sz);
            if ($urandom % 3 == 0) drain();
        end
        drain();

        // asynchronous reset mid-capture
        request(4, acked);
        wait_enable();
        deliver(4, 2, 32'h300, 1'b0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_enable_drop", o_in_path_enable, 1'b0);
        check("rst_count", o_fifo_count, 10'd0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_idle", o_busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
